// File: rtl/flash_xfer_scheduler.sv
// flash_xfer_scheduler: queues flash-to-DMA jobs and sequences the SPI flash controller register writes.
// Optional IRQ-wait timeout is compiled in when SEQ_TIMEOUT_EN is defined.
module flash_xfer_scheduler #(
  parameter logic [31:0] REG_BASE  = 32'h0000_0000,
  parameter int          Q_DEPTH   = 4,
  parameter int          TO_CYCLES = 1048576
) (
  input  logic        i_clk_ahb,
  input  logic        i_rst_ahb,
  input  logic        i_job_valid,
  output logic        o_job_ready,
  input  logic [23:0] i_job_flash_addr,
  input  logic [31:0] i_job_dma_addr,
  input  logic [23:0] i_job_len,
  output logic [31:0] o_addr,
  output logic [31:0] o_wr_data,
  output logic        o_rd0_wr1,
  output logic        o_valid,
  input  logic        i_ready,
  input  logic        i_spi_flash_irq,
  output logic        o_busy,
  output logic        o_done,
  output logic [4:0]  o_job_count,
  output logic        o_timeout
);

  // state    | meaning
  // IDLE     | wait for a queued job, pop it into the active registers
  // W_CCNT   | write 0x00 = 4 (command byte count)
  // W_DCNT   | write 0x04 = job length
  // W_DMA    | write 0x0C = DMA destination
  // W_MODE   | write 0x1C = 0 (single-line)
  // W_CMD    | write 0x10 = {READ 0x03, flash address}
  // W_START  | write 0x20 = 1 (kick transfer)
  // WAIT_IRQ | wait for transfer-complete IRQ (or timeout)
  // W_CLR    | write 0x24 = 1 (clear IRQ)
  // DONE     | pulse o_done, return to IDLE
  typedef enum logic [3:0] {
    IDLE, W_CCNT, W_DCNT, W_DMA, W_MODE, W_CMD, W_START, WAIT_IRQ, W_CLR, DONE
  } state_t;

  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  state_t        state, ns;
  logic [79:0]   q_mem [Q_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop;
  logic [79:0]   head;
  logic [23:0]   act_fa, act_ln, sel_fa, sel_ln;
  logic [31:0]   act_da, sel_da;
  logic [63:0]   cmd;
  logic          to_hit;

  assign full        = (o_job_count == 5'(Q_DEPTH));
  assign o_job_ready = !full && !i_rst_ahb;
  assign push        = i_job_valid && o_job_ready;
  assign pop         = (state == IDLE) && (o_job_count != 5'd0);
  assign head        = q_mem[rd_ptr];

  always_ff @(posedge i_clk_ahb) begin
    if (push) q_mem[wr_ptr] <= {i_job_flash_addr, i_job_dma_addr, i_job_len};
  end

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_job_count <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_job_count <= o_job_count + 5'd1;
        2'b01:   o_job_count <= o_job_count - 5'd1;
        default: o_job_count <= o_job_count;
      endcase
    end
  end

  function automatic logic is_write(state_t s);
    return (s == W_CCNT) || (s == W_DCNT) || (s == W_DMA) || (s == W_MODE) ||
           (s == W_CMD) || (s == W_START) || (s == W_CLR);
  endfunction

  // {offset, data} for the write issued in state s
  function automatic logic [63:0] wr_cmd(state_t s, logic [23:0] fa, logic [31:0] da,
                                         logic [23:0] ln);
    case (s)
      W_CCNT:  return {32'h0000_0000, 32'd4};
      W_DCNT:  return {32'h0000_0004, 8'h00, ln};
      W_DMA:   return {32'h0000_000C, da};
      W_MODE:  return {32'h0000_001C, 32'd0};
      W_CMD:   return {32'h0000_0010, 8'h03, fa};
      W_START: return {32'h0000_0020, 32'd1};
      W_CLR:   return {32'h0000_0024, 32'd1};
      default: return 64'd0;
    endcase
  endfunction

`ifdef SEQ_TIMEOUT_EN
  logic [31:0] to_cnt;
  assign to_hit = (to_cnt == 32'(TO_CYCLES - 1));

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      to_cnt    <= 32'd0;
      o_timeout <= 1'b0;
    end else begin
      to_cnt    <= (state == WAIT_IRQ) ? to_cnt + 32'd1 : 32'd0;
      o_timeout <= (state == WAIT_IRQ) && !i_spi_flash_irq && to_hit;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    ns = state;
    case (state)
      IDLE:     if (pop) ns = (head[23:0] == 24'd0) ? DONE : W_CCNT;
      W_CCNT:   if (i_ready) ns = W_DCNT;
      W_DCNT:   if (i_ready) ns = W_DMA;
      W_DMA:    if (i_ready) ns = W_MODE;
      W_MODE:   if (i_ready) ns = W_CMD;
      W_CMD:    if (i_ready) ns = W_START;
      W_START:  if (i_ready) ns = WAIT_IRQ;
      WAIT_IRQ: if (i_spi_flash_irq || to_hit) ns = W_CLR;
      W_CLR:    if (i_ready) ns = DONE;
      DONE:     ns = IDLE;
      default:  ns = IDLE;
    endcase
  end

  // the job being popped is not yet in the active registers, so read it from the queue head
  assign sel_fa = (state == IDLE) ? head[79:56] : act_fa;
  assign sel_da = (state == IDLE) ? head[55:24] : act_da;
  assign sel_ln = (state == IDLE) ? head[23:0]  : act_ln;
  assign cmd    = wr_cmd(ns, sel_fa, sel_da, sel_ln);

  always_ff @(posedge i_clk_ahb) begin
    if (i_rst_ahb) begin
      state     <= IDLE;
      o_valid   <= 1'b0;
      o_addr    <= 32'd0;
      o_wr_data <= 32'd0;
      o_rd0_wr1 <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      act_fa    <= 24'd0;
      act_da    <= 32'd0;
      act_ln    <= 24'd0;
    end else begin
      state     <= ns;
      o_valid   <= is_write(ns);
      o_rd0_wr1 <= is_write(ns);
      o_addr    <= is_write(ns) ? REG_BASE + cmd[63:32] : 32'd0;
      o_wr_data <= cmd[31:0];
      o_busy    <= (ns != IDLE);
      o_done    <= (ns == DONE);
      if (pop) begin
        act_fa <= head[79:56];
        act_da <= head[55:24];
        act_ln <= head[23:0];
      end
    end
  end

endmodule

// File: tb/tb_flash_xfer_scheduler.sv
// Directed self-checking bench for flash_xfer_scheduler (timeout scenario built only with SEQ_TIMEOUT_EN).
module tb_flash_xfer_scheduler;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [23:0] job_fa;
  logic [31:0] job_da;
  logic [23:0] job_ln;
  logic [31:0] addr, wr_data;
  logic        rd0_wr1, valid, ready, irq, busy, done, tmo;
  logic [4:0]  job_count;

  int checks = 0;
  int errors = 0;
  int done_cnt, valid_cycles, tmo_seen, dir_err;
  logic [63:0] wq[$];

  always #5 clk = ~clk;

  flash_xfer_scheduler #(.REG_BASE(BASE), .Q_DEPTH(4), .TO_CYCLES(16)) dut (
    .i_clk_ahb(clk), .i_rst_ahb(rst),
    .i_job_valid(job_valid), .o_job_ready(job_ready),
    .i_job_flash_addr(job_fa), .i_job_dma_addr(job_da), .i_job_len(job_ln),
    .o_addr(addr), .o_wr_data(wr_data), .o_rd0_wr1(rd0_wr1), .o_valid(valid),
    .i_ready(ready), .i_spi_flash_irq(irq), .o_busy(busy), .o_done(done),
    .o_job_count(job_count), .o_timeout(tmo)
  );

  // bus/event recorder: inputs change just after posedge, so negedge sees a settled cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) wq.push_back({addr, wr_data});
      if (valid) valid_cycles++;
      if (valid && !rd0_wr1) dir_err++;
      if (done) done_cnt++;
      if (tmo) tmo_seen++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_wr(int i, logic [23:0] fa, logic [31:0] da, logic [23:0] ln);
    case (i)
      0:       return {BASE + 32'h00, 32'd4};
      1:       return {BASE + 32'h04, {8'd0, ln}};
      2:       return {BASE + 32'h0C, da};
      3:       return {BASE + 32'h1C, 32'd0};
      4:       return {BASE + 32'h10, {8'h03, fa}};
      5:       return {BASE + 32'h20, 32'd1};
      default: return {BASE + 32'h24, 32'd1};
    endcase
  endfunction

  task automatic clear_log();
    wq.delete();
    done_cnt = 0; valid_cycles = 0; tmo_seen = 0; dir_err = 0;
  endtask

  task automatic push_job(input logic [23:0] fa, input logic [31:0] da, input logic [23:0] ln);
    job_fa = fa; job_da = da; job_ln = ln; job_valid = 1'b1;
    step();
    job_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; job_valid = 1'b0; job_fa = '0; job_da = '0; job_ln = '0;
    ready = 1'b0; irq = 1'b0;
    step(); step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (job_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", job_count); end
    checks++; if ({addr, wr_data, rd0_wr1, done, tmo} !== 67'd0) begin errors++;
      $display("FAIL reset_outputs: addr=%h data=%h dir=%b done=%b tmo=%b want all 0", addr, wr_data, rd0_wr1, done, tmo); end
    checks++; if (job_ready !== 1'b0) begin errors++; $display("FAIL reset_job_ready: got %b want 0", job_ready); end
    rst = 1'b0;
    step();
    checks++; if (job_ready !== 1'b1) begin errors++; $display("FAIL post_reset_job_ready: got %b want 1", job_ready); end
  endtask

  task automatic test_single();
    int n;
    clear_log(); ready = 1'b1; irq = 1'b0;
    push_job(24'h001000, 32'h2000_0000, 24'd256);
    n = 0; while (wq.size() < 6 && n < 60) begin step(); n++; end
    checks++; if (wq.size() != 6) begin errors++; $display("FAIL single_start: writes=%0d want 6", wq.size()); end
    repeat (49) step();
    checks++; if (wq.size() != 6 || busy !== 1'b1 || valid !== 1'b0) begin errors++;
      $display("FAIL single_wait_irq: writes=%0d busy=%b valid=%b want 6/1/0", wq.size(), busy, valid); end
    irq = 1'b1;
    n = 0; while (wq.size() < 7 && n < 20) begin step(); n++; end
    irq = 1'b0;
    n = 0; while (busy && n < 20) begin step(); n++; end
    step();
    checks++; if (wq.size() != 7) begin errors++; $display("FAIL single_count: writes=%0d want 7", wq.size()); end
    for (int i = 0; i < 7 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_wr(i, 24'h001000, 32'h2000_0000, 24'd256)) begin errors++;
        $display("FAIL single_wr%0d: got %h want %h", i, wq[i], exp_wr(i, 24'h001000, 32'h2000_0000, 24'd256)); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL single_done: pulses=%0d want 1", done_cnt); end
    checks++; if (dir_err != 0 || tmo_seen != 0) begin errors++;
      $display("FAIL single_dir_tmo: dir_err=%0d tmo=%0d want 0/0", dir_err, tmo_seen); end
  endtask

  task automatic test_stall();
    int n;
    logic [31:0] a0, d0;
    clear_log(); ready = 1'b1; irq = 1'b0;
    push_job(24'hABCDEF, 32'h1234_5678, 24'h000040);
    n = 0; while (!(valid && addr == BASE + 32'h0C) && n < 20) begin step(); n++; end
    ready = 1'b0; irq = 1'b1;
    a0 = addr; d0 = wr_data;
    checks++; if (a0 !== BASE + 32'h0C || d0 !== 32'h1234_5678) begin errors++;
      $display("FAIL stall_entry: addr=%h data=%h want %h/12345678", a0, d0, BASE + 32'h0C); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (valid !== 1'b1 || addr !== a0 || wr_data !== d0) begin errors++;
        $display("FAIL stall_hold%0d: valid=%b addr=%h data=%h want 1/%h/%h", i, valid, addr, wr_data, a0, d0); end
    end
    irq = 1'b0; ready = 1'b1;
    n = 0; while (wq.size() < 6 && n < 20) begin step(); n++; end
    step();
    irq = 1'b1;
    n = 0; while (busy && n < 20) begin step(); n++; end
    irq = 1'b0;
    step();
    checks++; if (wq.size() != 7) begin errors++; $display("FAIL stall_count: writes=%0d want 7", wq.size()); end
    for (int i = 0; i < 7 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== exp_wr(i, 24'hABCDEF, 32'h1234_5678, 24'h000040)) begin errors++;
        $display("FAIL stall_wr%0d: got %h want %h", i, wq[i], exp_wr(i, 24'hABCDEF, 32'h1234_5678, 24'h000040)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] fa_t [5];
    logic [31:0] da_t [5];
    logic [23:0] ln_t [5];
    int n;
    logic acc;
    clear_log(); ready = 1'b1; irq = 1'b1;
    for (int j = 0; j < 5; j++) begin
      fa_t[j] = 24'h100000 + 24'(j * 24'h111);
      da_t[j] = 32'h8000_0000 + 32'(j * 32'h1000);
      ln_t[j] = 24'(j + 1);
    end
    for (int j = 0; j < 5; j++) begin
      job_fa = fa_t[j]; job_da = da_t[j]; job_ln = ln_t[j]; job_valid = 1'b1;
      acc = 1'b0; n = 0;
      while (!acc && n < 200) begin
        acc = job_ready;
        step(); n++;
      end
      checks++; if (!acc) begin errors++; $display("FAIL b2b_push%0d: accepted=0 want 1", j); end
    end
    job_valid = 1'b0;
    checks++; if (job_count !== 5'd4 || job_ready !== 1'b0) begin errors++;
      $display("FAIL b2b_full: count=%0d ready=%b want 4/0", job_count, job_ready); end
    n = 0; while ((busy || job_count != 0) && n < 600) begin step(); n++; end
    step();
    irq = 1'b0;
    checks++; if (done_cnt != 5) begin errors++; $display("FAIL b2b_done: pulses=%0d want 5", done_cnt); end
    checks++; if (wq.size() != 35) begin errors++; $display("FAIL b2b_count: writes=%0d want 35", wq.size()); end
    for (int j = 0; j < 5; j++)
      for (int i = 0; i < 7; i++)
        if (j * 7 + i < wq.size()) begin
          checks++;
          if (wq[j*7+i] !== exp_wr(i, fa_t[j], da_t[j], ln_t[j])) begin errors++;
            $display("FAIL b2b_job%0d_wr%0d: got %h want %h", j, i, wq[j*7+i], exp_wr(i, fa_t[j], da_t[j], ln_t[j])); end
        end
  endtask

  task automatic test_len_zero();
    clear_log(); ready = 1'b1; irq = 1'b0;
    push_job(24'h00FF00, 32'hDEAD_0000, 24'd0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL len0_early_done: got %b want 0", done); end
    step();
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++;
      $display("FAIL len0_done: done=%b busy=%b want 1/1", done, busy); end
    step();
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL len0_after: done=%b busy=%b want 0/0", done, busy); end
    repeat (3) step();
    checks++; if (valid_cycles != 0 || done_cnt != 1) begin errors++;
      $display("FAIL len0_bus: valid_cycles=%0d done=%0d want 0/1", valid_cycles, done_cnt); end
  endtask

  task automatic test_reset_mid_write();
    int n, wsz;
    clear_log(); ready = 1'b1; irq = 1'b0;
    push_job(24'h000100, 32'h0000_1000, 24'd8);
    push_job(24'h000200, 32'h0000_2000, 24'd8);
    push_job(24'h000300, 32'h0000_3000, 24'd8);
    n = 0; while (!(valid && addr == BASE + 32'h10) && n < 20) begin step(); n++; end
    checks++; if (job_count !== 5'd2) begin errors++; $display("FAIL rstmid_queued: count=%0d want 2", job_count); end
    rst = 1'b1;
    step();
    wsz = wq.size();
    checks++; if (valid !== 1'b0 || job_count !== 5'd0 || busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_state: valid=%b count=%0d busy=%b want 0/0/0", valid, job_count, busy); end
    rst = 1'b0; irq = 1'b1;
    repeat (30) step();
    irq = 1'b0;
    checks++; if (wsz != 4 || wq.size() != wsz || done_cnt != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL rstmid_quiet: before=%0d after=%0d done=%0d busy=%b want 4/4/0/0", wsz, wq.size(), done_cnt, busy); end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    int early;
    clear_log(); ready = 1'b1; irq = 1'b0;
    push_job(24'h000500, 32'h0000_5000, 24'd4);
    n = 0; while (wq.size() < 6 && n < 30) begin step(); n++; end
    early = 0;
    for (int k = 0; k < 15; k++) begin step(); if (tmo) early++; end
    checks++; if (early != 0) begin errors++; $display("FAIL tmo_early: pulses=%0d want 0", early); end
    step();
    checks++; if (tmo !== 1'b1 || valid !== 1'b1 || addr !== BASE + 32'h24) begin errors++;
      $display("FAIL tmo_pulse: tmo=%b valid=%b addr=%h want 1/1/%h", tmo, valid, addr, BASE + 32'h24); end
    step();
    checks++; if (tmo !== 1'b0 || done !== 1'b1) begin errors++;
      $display("FAIL tmo_done: tmo=%b done=%b want 0/1", tmo, done); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_len_zero();
    test_reset_mid_write();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
